spi_ram_responder: RTL and testbench

- SPI mode-0 target that emulates a byte-addressed serial SRAM; the far end of the SPI link from our SPI RAM controller.
- Used for simulation and for on-chip loopback tests.
- Oversamples SCK, CS and MOSI on the system clock, then decodes command, address and data.
- Serves READ (0x03) and WRITE (0x02) from an internal memory, with sequential auto-increment.

---
 rtl/spi_ram_responder_if.sv | 24 ++
 rtl/spi_ram_responder.sv | 197 +++++++++++++++++++
 tb/tb_spi_ram_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_responder_if.sv
// SPI pins and committed-write strobe for spi_ram_responder.
// master drives the SPI link; slave is the responder side.
interface spi_ram_responder_if #(
  parameter int MEM_ADDR_BITS = 10
);
  logic                     spi_select;
  logic                     spi_clk_in;
  logic                     spi_mosi;
  logic                     spi_miso;
  logic                     wr_valid;
  logic [MEM_ADDR_BITS-1:0] wr_addr;
  logic [7:0]               wr_data;
  logic                     active;

  modport master (
    output spi_select, spi_clk_in, spi_mosi,
    input  spi_miso, wr_valid, wr_addr, wr_data, active
  );

  modport slave (
    input  spi_select, spi_clk_in, spi_mosi,
    output spi_miso, wr_valid, wr_addr, wr_data, active
  );
endinterface

// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial SRAM target; SCK/CS/MOSI are oversampled on i_clk.
// Define SPI_RAM_RESPONDER_STATUS_EN to add RDSR/WRSR and byte-mode addressing.
module spi_ram_responder #(
  parameter int ADDR_BITS     = 16,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spi_ram_responder_if.slave io_bus
);
`ifdef SPI_RAM_RESPONDER_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif
  localparam int               CNT_W    = $clog2(ADDR_BITS > 8 ? ADDR_BITS : 8);
  localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_BITS - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StRdata, StWdata, StIgnore} state_e;

  state_e                   r_state, w_state_nxt;
  logic [1:0]               r_sel_s, r_mosi_s;
  logic [2:0]               r_sck_s;
  logic [CNT_W-1:0]         r_cnt;
  logic [6:0]               r_shift;
  logic [MEM_ADDR_BITS-1:0] r_ptr, r_wr_addr;
  logic                     r_is_read, r_is_sr, r_load, r_miso, r_wr_valid;
  logic [7:0]               r_tx, r_wr_data, r_mode, r_rd_data;
  logic [7:0]               r_mem [2**MEM_ADDR_BITS];

  logic                     w_sel, w_mosi, w_rise, w_fall, w_last, w_inc;
  logic                     w_cmd_rd, w_cmd_wr, w_cmd_rdsr, w_cmd_wrsr;
  logic                     w_rd_en, w_wr_en;
  logic [7:0]               w_cmd;
  logic [MEM_ADDR_BITS-1:0] w_addr, w_ptr_inc, w_rd_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel_s  <= 2'b11;
      r_sck_s  <= '0;
      r_mosi_s <= '0;
    end else begin
      r_sel_s  <= {r_sel_s[0], io_bus.spi_select};
      r_sck_s  <= {r_sck_s[1:0], io_bus.spi_clk_in};
      r_mosi_s <= {r_mosi_s[0], io_bus.spi_mosi};
    end
  end

  assign w_sel      = r_sel_s[1];
  assign w_mosi     = r_mosi_s[1];
  assign w_rise     = r_sck_s[1] & ~r_sck_s[2];
  assign w_fall     = ~r_sck_s[1] & r_sck_s[2];
  assign w_last     = (r_cnt == '0);
  assign w_cmd      = {r_shift, w_mosi};
  // The address shifts straight into the pointer; upper wire bits fall off the top.
  assign w_addr     = {r_ptr[MEM_ADDR_BITS-2:0], w_mosi};
  assign w_inc      = !STATUS_EN || (r_mode[7:6] != 2'b00);
  assign w_ptr_inc  = w_inc ? r_ptr + MEM_ADDR_BITS'(1) : r_ptr;
  assign w_cmd_rd   = (w_cmd == 8'h03);
  assign w_cmd_wr   = (w_cmd == 8'h02);
  assign w_cmd_rdsr = STATUS_EN && (w_cmd == 8'h05);
  assign w_cmd_wrsr = STATUS_EN && (w_cmd == 8'h01);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_ptr;
    w_wr_en     = 1'b0;
    if (w_sel) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle: w_state_nxt = StCmd;
        StCmd: begin
          if (w_rise && w_last) begin
            if (w_cmd_rd || w_cmd_wr) w_state_nxt = StAddr;
            else if (w_cmd_rdsr)      w_state_nxt = StRdata;
            else if (w_cmd_wrsr)      w_state_nxt = StWdata;
            else                      w_state_nxt = StIgnore;
          end
        end
        StAddr: begin
          if (w_rise && w_last) begin
            if (r_is_read) begin
              w_state_nxt = StRdata;
              w_rd_en     = 1'b1;
              w_rd_addr   = w_addr;
            end else begin
              w_state_nxt = StWdata;
            end
          end
        end
        StRdata: begin
          if (w_fall && w_last && !r_is_sr) begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_ptr_inc;
          end
        end
        StWdata: w_wr_en = w_rise && w_last && !r_is_sr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_ptr] <= w_cmd;
    if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_is_read  <= 1'b0;
      r_is_sr    <= 1'b0;
      r_tx       <= '0;
      r_load     <= 1'b0;
      r_miso     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_mode     <= 8'h40;
    end else begin
      r_wr_valid <= 1'b0;
      r_load     <= w_rd_en;
      if (r_load) r_tx <= r_rd_data;
      if (w_sel) begin
        r_miso <= 1'b0;
        r_cnt  <= CNT_BYTE;
      end else begin
        case (r_state)
          StIdle: r_cnt <= CNT_BYTE;
          StCmd: begin
            if (w_rise) begin
              r_shift <= w_cmd[6:0];
              if (w_last) begin
                r_cnt     <= (w_cmd_rd || w_cmd_wr) ? CNT_ADDR : CNT_BYTE;
                r_is_read <= w_cmd_rd || w_cmd_rdsr;
                r_is_sr   <= w_cmd_rdsr || w_cmd_wrsr;
                if (w_cmd_rdsr) r_tx <= r_mode;
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
          end
          StAddr: begin
            if (w_rise) begin
              r_ptr <= w_addr;
              r_cnt <= w_last ? CNT_BYTE : r_cnt - CNT_W'(1);
            end
          end
          StRdata: begin
            if (w_fall) begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
              r_cnt  <= w_last ? CNT_BYTE : r_cnt - CNT_W'(1);
              if (w_last) begin
                if (r_is_sr) r_tx  <= r_mode;
                else         r_ptr <= w_ptr_inc;
              end
            end
          end
          StWdata: begin
            if (w_rise) begin
              r_shift <= w_cmd[6:0];
              r_cnt   <= w_last ? CNT_BYTE : r_cnt - CNT_W'(1);
              if (w_last) begin
                if (r_is_sr) begin
                  r_mode <= w_cmd;
                end else begin
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_ptr;
                  r_wr_data  <= w_cmd;
                  r_ptr      <= w_ptr_inc;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.spi_miso = r_miso;
  assign io_bus.wr_valid = r_wr_valid;
  assign io_bus.wr_addr  = r_wr_addr;
  assign io_bus.wr_data  = r_wr_data;
  assign io_bus.active   = (r_state != StIdle);
endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: SPI controller tasks plus write/read scoreboards.
module tb_spi_ram_responder;
  localparam int MAB  = 10;
  localparam int HALF = 5;  // SCK half period in clk cycles (10x oversampling)

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_responder_if #(.MEM_ADDR_BITS(MAB)) bus ();

  spi_ram_responder #(.ADDR_BITS(16), .MEM_ADDR_BITS(MAB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus.slave)
  );

  int             n_checks = 0;
  int             n_errors = 0;
  int             n_wr     = 0;
  logic [MAB+7:0] wr_q [$];
  logic [7:0]     rd_q [$];
  logic [7:0]     model [2**MAB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_mosi = tx[i];
      wait_clks(HALF);
      rx[i] = bus.spi_miso;
      bus.spi_clk_in = 1'b1;
      wait_clks(HALF);
      bus.spi_clk_in = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_select = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    bus.spi_select = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr);
    logic [7:0] d;
    spi_bits(cmd, 8, d);
    spi_bits(addr[15:8], 8, d);
    spi_bits(addr[7:0], 8, d);
  endtask

  task automatic write_bytes(input logic [15:0] addr, input logic [31:0] data, input int n);
    logic [7:0]     d;
    logic [7:0]     b;
    logic [MAB-1:0] a;
    cs_low();
    send_hdr(8'h02, addr);
    for (int k = 0; k < n; k++) begin
      b = data[8*(n-1-k) +: 8];
      a = MAB'(addr) + MAB'(k);
      wr_q.push_back({a, b});
      model[a] = b;
      spi_bits(b, 8, d);
    end
    cs_high();
    check("wr_drain", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic read_bytes(input logic [15:0] addr, input int n, output logic [31:0] word);
    logic [7:0]     d;
    logic [7:0]     e;
    logic [MAB-1:0] a;
    word = '0;
    cs_low();
    send_hdr(8'h03, addr);
    for (int k = 0; k < n; k++) begin
      a = MAB'(addr) + MAB'(k);
      rd_q.push_back(model[a]);
      spi_bits(8'h00, 8, d);
      e = rd_q.pop_front();
      check($sformatf("rd_%03h", a), 32'(d), 32'(e));
      word = {word[23:0], d};
    end
    cs_high();
  endtask

  always @(negedge clk) begin : wr_mon
    logic [MAB+7:0] e;
    if (bus.wr_valid === 1'b1) begin
      n_wr++;
      check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e[MAB+7:8]));
        check("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  d;
    int          wr0;
    bus.spi_select = 1'b1;
    bus.spi_clk_in = 1'b0;
    bus.spi_mosi   = 1'b0;
    wait_clks(4);
    check("rst_miso",     32'(bus.spi_miso), 32'd0);
    check("rst_active",   32'(bus.active),   32'd0);
    check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    check("rst_wr_data",  32'(bus.wr_data),  32'd0);
    rst = 1'b0;
    wait_clks(4);
    check("idle_active", 32'(bus.active), 32'd0);

    // Sequential write then read-back
    wr0 = n_wr;
    write_bytes(16'h0010, 32'hDEADBEEF, 4);
    check("wr_count", 32'(n_wr - wr0), 32'd4);
    read_bytes(16'h0010, 4, w);
    check("rd_word", w, 32'hDEADBEEF);

    // Pointer wrap at the top of memory
    wr0 = n_wr;
    write_bytes(16'h03FF, 32'h0000A55A, 2);
    check("wrap_count", 32'(n_wr - wr0), 32'd2);
    read_bytes(16'h03FF, 2, w);
    check("wrap_word", 32'(w[15:0]), 32'h0000A55A);

    // Upper wire address bits are ignored
    read_bytes(16'hFC10, 1, w);
    check("hi_addr_word", 32'(w[7:0]), 32'h000000DE);

    // Abort mid-byte: partial byte never lands
    write_bytes(16'h0021, 32'h00000077, 1);
    wr0 = n_wr;
    cs_low();
    send_hdr(8'h02, 16'h0020);
    wr_q.push_back({10'h020, 8'h12});
    model[10'h020] = 8'h12;
    spi_bits(8'h12, 8, d);
    spi_bits(8'hFF, 4, d);
    cs_high();
    check("abort_count", 32'(n_wr - wr0), 32'd1);
    check("abort_drain", 32'(wr_q.size()), 32'd0);
    read_bytes(16'h0020, 2, w);
    check("abort_word", 32'(w[15:0]), 32'h00001277);

    // Unknown command: MISO stays low, no writes
    wr0 = n_wr;
    cs_low();
    spi_bits(8'h9F, 8, d);
    check("ign_active", 32'(bus.active), 32'd1);
    for (int k = 0; k < 3; k++) begin
      spi_bits(8'hA5, 8, d);
      check($sformatf("ign_miso_%0d", k), 32'(d), 32'd0);
    end
    cs_high();
    check("ign_wr_count", 32'(n_wr - wr0), 32'd0);
    read_bytes(16'h0010, 1, w);
    check("after_ign_word", 32'(w[7:0]), 32'h000000DE);

    // Reset in the middle of a read
    cs_low();
    send_hdr(8'h03, 16'h0010);
    wait_clks(HALF);
    check("pre_rst_miso",   32'(bus.spi_miso), 32'd1);
    check("pre_rst_active", 32'(bus.active),   32'd1);
    rst = 1'b1;
    wait_clks(1);
    check("mid_rst_miso",   32'(bus.spi_miso), 32'd0);
    check("mid_rst_active", 32'(bus.active),   32'd0);
    rst = 1'b0;
    bus.spi_select = 1'b1;
    wait_clks(2 * HALF);
    read_bytes(16'h0010, 4, w);
    check("post_rst_word", w, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
